// File: rtl/bsg_wormhole_packet_arbiter.sv
// Round-robin wormhole packet arbiter: shares one output link among num_in_p inputs,
// holding the grant for a whole packet (header plus len body flits).
module bsg_wormhole_packet_arbiter #(
   parameter int num_in_p     = 2,
   parameter int flit_width_p = 32,
   parameter int cord_width_p = 7,
   parameter int len_width_p  = 3
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [num_in_p-1:0]              v_i,
   input  logic [num_in_p*flit_width_p-1:0] data_i,
   output logic [num_in_p-1:0]              ready_and_o,
   output logic                             v_o,
   output logic [flit_width_p-1:0]          data_o,
   input  logic                             ready_and_i,
   output logic [num_in_p-1:0]              grant_o,
   output logic                             busy_o
);

   localparam int sel_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

   typedef enum logic {
      e_idle,
      e_busy
   } state_e;

   state_e                  state_q, state_d;
   logic [sel_width_lp-1:0] sel_q, sel_d;
   logic [sel_width_lp-1:0] last_q, last_d;
   logic [len_width_p-1:0]  count_q, count_d;

   logic [sel_width_lp-1:0] pick;
   logic                    pick_v;
   logic [sel_width_lp-1:0] grant_sel;
   logic                    grant_v;
   logic                    xfer;
   logic [len_width_p-1:0]  hdr_len;

   // Search starts just past the last input to finish a packet, so it becomes lowest priority.
   always_comb begin
      int                      idx;
      logic [sel_width_lp-1:0] idx_s;
      pick   = '0;
      pick_v = 1'b0;
      idx    = 0;
      idx_s  = '0;
      for (int k = 1; k <= num_in_p; k++) begin
         idx = int'(last_q) + k;
         if (idx >= num_in_p) idx = idx - num_in_p;
         idx_s = sel_width_lp'(idx);
         if (!pick_v && v_i[idx_s]) begin
            pick_v = 1'b1;
            pick   = idx_s;
         end
      end
   end

   assign grant_sel = (state_q == e_busy) ? sel_q : pick;
   assign grant_v   = !reset_i && ((state_q == e_busy) || pick_v);

   always_comb begin
      grant_o = '0;
      data_o  = '0;
      for (int i = 0; i < num_in_p; i++) begin
         if (grant_sel == sel_width_lp'(i)) begin
            grant_o[i] = grant_v;
            data_o     = data_i[i*flit_width_p +: flit_width_p];
         end
      end
   end

   assign v_o         = grant_v & v_i[grant_sel];
   assign ready_and_o = grant_o & {num_in_p{ready_and_i}};
   assign busy_o      = (state_q == e_busy) && !reset_i;
   assign xfer        = v_o & ready_and_i;
   assign hdr_len     = data_o[cord_width_p +: len_width_p];

   // Body flits are never parsed; len comes from the header only.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      count_d = count_q;
      unique case (state_q)
         e_idle: begin
            if (xfer) begin
               if (hdr_len == '0) begin
                  last_d = pick;
               end else begin
                  state_d = e_busy;
                  sel_d   = pick;
                  count_d = hdr_len;
               end
            end
         end
         e_busy: begin
            if (xfer) begin
               count_d = count_q - len_width_p'(1);
               if (count_q == len_width_p'(1)) begin
                  state_d = e_idle;
                  last_d  = sel_q;
               end
            end
         end
         default: state_d = e_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= e_idle;
         sel_q   <= '0;
         last_q  <= sel_width_lp'(num_in_p - 1);
         count_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

`ifndef SYNTHESIS
   // The selected input may bubble mid-packet, so only grant shape is checked.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert ($onehot0(grant_o));
      end
   end
`endif

endmodule

// File: doc/bsg_wormhole_packet_arbiter.md
Name: bsg_wormhole_packet_arbiter

Overview:
- Shares one wormhole output link among num_in_p wormhole input links, one whole packet at a time.
- Each packet is a header flit plus the number of body flits given in the header's len field.
- Intended use: in front of a shared off-pod endpoint (uncached IO, test memory) fed by the north and south pod wormhole routers' P ports.
- Grant is round-robin and fixed for the full packet, so flits from different packets never interleave.

Parameters:
num_in_p, 2, number of input links (>=2)
flit_width_p, 32, flit width in bits
cord_width_p, 7, header destination cord field, bits [cord_width_p-1:0]
len_width_p, 3, header len field, bits [cord_width_p +: len_width_p]; len = number of body flits after the header

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
v_i  in  num_in_p  per-input flit valid
data_i  in  num_in_p*flit_width_p  per-input flit; input i occupies slice i
ready_and_o  out  num_in_p  per-input ready (ready-and handshake)
v_o  out  1  output flit valid
data_o  out  flit_width_p  output flit
ready_and_i  in  1  downstream ready
grant_o  out  num_in_p  one-hot: the input currently driving the output; 0 when none
busy_o  out  1  high while a multi-flit packet is mid-transfer (BUSY state)

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous and active-high.
- Handshake: a flit transfers in a cycle where v_o & ready_and_i.
  - ready_and_o[i] = ready_and_i & grant_o[i].
  - Non-granted inputs always see ready_and_o = 0.
- Datapath: fully combinational, zero latency. data_o = data_i[sel]; v_o = v_i[sel] & (grant_o != 0). No buffering in the block.
- State: state {IDLE, BUSY}, sel_r (clog2 num_in_p bits), count_r (len_width_p bits), last_r (last input that completed a packet).
- Reset:
  - state = IDLE, count_r = 0, last_r = num_in_p-1, so input 0 has top priority first.
  - During reset, grant_o = 0, v_o = 0, ready_and_o = 0, busy_o = 0.
- IDLE:
  - Round-robin pick: the first i with v_i[i] = 1, searching from last_r+1 upward with wrap modulo num_in_p.
  - grant_o is one-hot of the pick, or 0 if no input is valid.
  - The pick is tentative and may change each cycle until the header handshakes. An input may drop v_i before being granted.
  - On header handshake with len = 0: stay IDLE, last_r <= pick.
  - On header handshake with len > 0: go BUSY, sel_r <= pick, count_r <= len.
- BUSY:
  - grant_o = one-hot(sel_r), independent of other inputs' valids. busy_o = 1.
  - Each handshake decrements count_r.
  - Handshake with count_r = 1: go IDLE, last_r <= sel_r.
  - A bubble (v_i[sel_r] = 0) or backpressure (ready_and_i = 0) holds all state.
- Simultaneous events:
  - A new packet from another input can be picked in the IDLE cycle directly after BUSY exits. Its header may transfer in that cycle.
  - The just-finished input is now lowest priority.
- Width rules:
  - len is read only from the header flit; body flits are not parsed.
  - len = 2^len_width_p - 1 is legal, giving the maximum packet.
  - count_r never underflows because BUSY always exits at 1.
- Reset asserted mid-packet aborts to IDLE on the next edge. Residual flits of the aborted packet are the upstream's problem; the block assumes upstream is reset too.
- Fairness: with all inputs continuously valid, grants rotate 0,1,...,num_in_p-1,0 per packet.
- Assertions (nonsynth): grant_o is one-hot or zero; in BUSY, v_i[sel_r] is not required to be continuous.

Test Plan:
- Single input: in0 sends a len=2 packet (3 flits) with ready_and_i=1 throughout -> v_o high 3 cycles, data_o matches flits in order, busy_o high exactly during cycles 2-3, grant_o=01 throughout.
- Contention: in0 and in1 both valid from reset, each with len=1 packets -> output order in0 H,B, then in1 H,B, then in0. grant_o=01,01,10,10,01; ready_and_o never high on the loser.
- Lock under contention: in1 presents a len=3 packet mid-transfer; in0 asserts v_i for a header -> in0 receives ready_and_o=0 until in1's 4th flit handshakes; in0's header transfers the following cycle or the same IDLE cycle.
- Backpressure and bubbles: len=4 packet; ready_and_i toggles 1,0,1,0 and upstream drops v_i for 2 cycles -> exactly 5 flits out, no duplication or loss, count_r holds during stalls.
- Zero-length packets: in0 and in1 send back-to-back len=0 headers -> state stays IDLE, one flit per cycle, alternating in0, in1, in0; busy_o=0 always.
- Reset mid-packet: assert reset_i after the header of a len=5 packet from in1 -> next cycle busy_o=0, grant_o=0. After release, in0 wins the first arbitration even if in1 is valid.
